// File: rtl/rto_arb_pkg.sv
// Shared types and constants for the RTO core FIFO write arbiter.
package rto_arb_pkg;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        FLUSH = 2'd1,
        DONE  = 2'd2
    } arb_state_t;

    // Width of the flush-length down-counter
    localparam int CNT_WIDTH  = 8;

    // Width of one per-requester transfer statistics counter
    localparam int STAT_WIDTH = 32;

    // Index width for a requester id; a single requester still gets one bit
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rto_write_arbiter_rr.sv
// Round-robin priority pick: finds the first asserted request after the last grant.
module rr_arbiter
    import rto_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]           req,
    input  logic [id_width(NUM_REQ)-1:0] last_grant,
    output logic [NUM_REQ-1:0]           grant,
    output logic [id_width(NUM_REQ)-1:0] grant_idx,
    output logic                         grant_valid
);

    localparam int IW = id_width(NUM_REQ);

    // Walk the requesters starting just after the previous winner and take the first valid one
    always_comb begin
        int idx;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        idx         = 0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = (int'(last_grant) + off) % NUM_REQ;
            if (!grant_valid && req[idx]) begin
                grant[idx]  = 1'b1;
                grant_idx   = IW'(idx);
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rto_write_arbiter.sv
// Shares one RTO core FIFO write port between NUM_REQ requesters with round-robin
// arbitration and sequences FIFO flushes.
// Optional macro RTO_ARB_STATS_EN adds per-requester saturating transfer counters
// on output write_count.
module rto_write_arbiter
    import rto_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = 128,
    parameter int FLUSH_CYCLES = 4
) (
    input  logic                          s_axi_aclk,
    input  logic                          s_axi_aresetn,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          flush_req,
    output logic                          flush_done,
    output logic                          rto_core_write,
    output logic [DATA_WIDTH-1:0]         rto_core_fifo_din,
    output logic                          rto_core_flush,
    input  logic                          rto_core_full,
    output logic [id_width(NUM_REQ)-1:0]  grant_id
`ifdef RTO_ARB_STATS_EN
    ,
    output logic [NUM_REQ*STAT_WIDTH-1:0] write_count
`endif
);

    localparam int IW = id_width(NUM_REQ);

    arb_state_t           state;
    arb_state_t           state_next;
    logic [CNT_WIDTH-1:0] flush_cnt;
    logic [CNT_WIDTH-1:0] flush_cnt_next;
    logic [IW-1:0]        grant_id_next;
    logic [NUM_REQ-1:0]   pick_grant;
    logic [IW-1:0]        pick_idx;
    logic                 pick_valid;
    logic                 transfer;

    rr_arbiter #(
        .NUM_REQ     (NUM_REQ)
    ) u_rr (
        .req         (req_valid),
        .last_grant  (grant_id),
        .grant       (pick_grant),
        .grant_idx   (pick_idx),
        .grant_valid (pick_valid)
    );

    // State, flush counter and last-grant registers
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state     <= ARB;
            flush_cnt <= '0;
            grant_id  <= IW'(NUM_REQ - 1);
        end else begin
            state     <= state_next;
            flush_cnt <= flush_cnt_next;
            grant_id  <= grant_id_next;
        end
    end

    // Next-state logic plus zero-latency write path; outputs held quiet while reset is low
    always_comb begin
        state_next        = state;
        flush_cnt_next    = flush_cnt;
        grant_id_next     = grant_id;
        transfer          = 1'b0;
        req_ready         = '0;
        rto_core_fifo_din = '0;
        rto_core_flush    = 1'b0;
        flush_done        = 1'b0;
        case (state)
            ARB: begin
                if (flush_req) begin
                    state_next     = FLUSH;
                    flush_cnt_next = CNT_WIDTH'(FLUSH_CYCLES);
                end else if (!rto_core_full && pick_valid) begin
                    transfer          = 1'b1;
                    req_ready         = pick_grant;
                    rto_core_fifo_din = req_data[pick_idx*DATA_WIDTH +: DATA_WIDTH];
                    grant_id_next     = pick_idx;
                end
            end
            FLUSH: begin
                rto_core_flush = 1'b1;
                flush_cnt_next = flush_cnt - CNT_WIDTH'(1);
                if (flush_cnt <= CNT_WIDTH'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                flush_done    = 1'b1;
                state_next    = ARB;
                grant_id_next = IW'(NUM_REQ - 1);
            end
            default: begin
                state_next = ARB;
            end
        endcase
        if (!s_axi_aresetn) begin
            transfer          = 1'b0;
            req_ready         = '0;
            rto_core_fifo_din = '0;
            rto_core_flush    = 1'b0;
            flush_done        = 1'b0;
        end
        rto_core_write = transfer;
    end

`ifdef RTO_ARB_STATS_EN
    logic [STAT_WIDTH-1:0] stat_cnt [NUM_REQ];

    // Per-requester saturating transfer counters, cleared when a flush completes
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            for (int i = 0; i < NUM_REQ; i++) stat_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (state == DONE) begin
                    stat_cnt[i] <= '0;
                end else if (transfer && pick_grant[i] && (stat_cnt[i] != '1)) begin
                    stat_cnt[i] <= stat_cnt[i] + STAT_WIDTH'(1);
                end
            end
        end
    end

    // Flatten the counters onto the statistics port
    always_comb begin
        write_count = '0;
        for (int i = 0; i < NUM_REQ; i++) write_count[i*STAT_WIDTH +: STAT_WIDTH] = stat_cnt[i];
    end
`endif

endmodule

// File: tb/tb_rto_write_arbiter.sv
// Self-checking bench for rto_write_arbiter: directed scenarios plus randomized traffic
// compared against a behavioural model every cycle.
module tb_rto_write_arbiter;
    import rto_arb_pkg::*;

    localparam int NUM_REQ      = 4;
    localparam int DATA_WIDTH   = 128;
    localparam int FLUSH_CYCLES = 4;
    localparam int IW           = id_width(NUM_REQ);

    logic                          clk;
    logic                          rst_n;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          flush_req;
    logic                          flush_done;
    logic                          rto_core_write;
    logic [DATA_WIDTH-1:0]         rto_core_fifo_din;
    logic                          rto_core_flush;
    logic                          rto_core_full;
    logic [IW-1:0]                 grant_id;
`ifdef RTO_ARB_STATS_EN
    logic [NUM_REQ*STAT_WIDTH-1:0] write_count;
`endif

    int checks;
    int errors;

    // Behavioural model: last winner, flush cycles still to run, pending done pulse
    int          m_last;
    int          m_flush_left;
    bit          m_done;
    logic [31:0] m_count [NUM_REQ];

    rto_write_arbiter #(
        .NUM_REQ           (NUM_REQ),
        .DATA_WIDTH        (DATA_WIDTH),
        .FLUSH_CYCLES      (FLUSH_CYCLES)
    ) dut (
        .s_axi_aclk        (clk),
        .s_axi_aresetn     (rst_n),
        .req_valid         (req_valid),
        .req_data          (req_data),
        .req_ready         (req_ready),
        .flush_req         (flush_req),
        .flush_done        (flush_done),
        .rto_core_write    (rto_core_write),
        .rto_core_fifo_din (rto_core_fifo_din),
        .rto_core_flush    (rto_core_flush),
        .rto_core_full     (rto_core_full),
        .grant_id          (grant_id)
`ifdef RTO_ARB_STATS_EN
        ,
        .write_count       (write_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string name, input logic [DATA_WIDTH-1:0] act,
                            input logic [DATA_WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        m_last       = NUM_REQ - 1;
        m_flush_left = 0;
        m_done       = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) m_count[i] = '0;
    endtask

    // Drive one cycle of inputs on the falling edge with fresh random data
    task automatic applyStimulus(input logic rst_v, input logic [NUM_REQ-1:0] valid_v,
                                 input logic full_v, input logic flush_v);
        @(negedge clk);
        rst_n         = rst_v;
        req_valid     = valid_v;
        rto_core_full = full_v;
        flush_req     = flush_v;
        for (int i = 0; i < NUM_REQ; i++)
            req_data[i*DATA_WIDTH +: DATA_WIDTH] = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    // Compare every output against the model, then advance the model to the next edge
    task automatic checkOutput();
        logic [NUM_REQ-1:0]    exp_ready;
        logic [DATA_WIDTH-1:0] exp_din;
        logic                  exp_flush;
        logic                  exp_done;
        int                    pick;
        #1;
        if (!rst_n) modelReset();
        exp_ready = '0;
        exp_din   = '0;
        exp_flush = 1'b0;
        exp_done  = 1'b0;
        pick      = -1;
        if (rst_n) begin
            if (m_done) exp_done = 1'b1;
            else if (m_flush_left > 0) exp_flush = 1'b1;
            else if (!flush_req && !rto_core_full) begin
                for (int off = 1; off <= NUM_REQ; off++) begin
                    int i;
                    i = (m_last + off) % NUM_REQ;
                    if (pick < 0 && req_valid[i]) pick = i;
                end
            end
        end
        if (pick >= 0) begin
            exp_ready[pick] = 1'b1;
            exp_din         = req_data[pick*DATA_WIDTH +: DATA_WIDTH];
        end
        checkVal("req_ready", req_ready, exp_ready);
        checkVal("rto_core_write", rto_core_write, (pick >= 0));
        checkVal("rto_core_fifo_din", rto_core_fifo_din, exp_din);
        checkVal("rto_core_flush", rto_core_flush, exp_flush);
        checkVal("flush_done", flush_done, exp_done);
        checkVal("grant_id", grant_id, m_last);
`ifdef RTO_ARB_STATS_EN
        for (int i = 0; i < NUM_REQ; i++)
            checkVal($sformatf("write_count%0d", i), write_count[i*32 +: 32], m_count[i]);
`endif
        if (rst_n) begin
            if (m_done) begin
                m_done = 1'b0;
                m_last = NUM_REQ - 1;
                for (int i = 0; i < NUM_REQ; i++) m_count[i] = '0;
            end else if (m_flush_left > 0) begin
                m_flush_left--;
                if (m_flush_left == 0) m_done = 1'b1;
            end else if (flush_req) begin
                m_flush_left = FLUSH_CYCLES;
            end else if (pick >= 0) begin
                m_last = pick;
                if (m_count[pick] != 32'hFFFF_FFFF) m_count[pick]++;
            end
        end
    endtask

    initial begin
        logic [NUM_REQ-1:0] seq [5];
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        req_valid     = '0;
        req_data      = '0;
        flush_req     = 1'b0;
        rto_core_full = 1'b0;
        modelReset();
        seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        // Reset with all requesters valid: everything quiet, grant_id at NUM_REQ-1
        applyStimulus(1'b0, 4'hF, 1'b0, 1'b0);
        checkOutput();
        checkVal("reset_grant_id", grant_id, 3);
        checkVal("reset_ready", req_ready, 0);

        // All valid continuously: grants rotate 0,1,2,3,0 with a write every cycle
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, 4'hF, 1'b0, 1'b0);
            checkOutput();
            checkVal("rr_seq_ready", req_ready, seq[k]);
            checkVal("rr_seq_write", rto_core_write, 1);
        end

        // Only requester 2 valid with a known word
        applyStimulus(1'b1, 4'b0100, 1'b0, 1'b0);
        req_data[2*DATA_WIDTH +: DATA_WIDTH] = 128'hA5;
        checkOutput();
        checkVal("single_ready", req_ready, 4'b0100);
        checkVal("single_din", rto_core_fifo_din, 128'hA5);
        applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0);
        checkOutput();
        checkVal("single_grant_id", grant_id, 2);

        // FIFO full for 5 cycles blocks everything; afterwards requester 3 is next
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, 4'hF, 1'b1, 1'b0);
            checkOutput();
            checkVal("full_ready", req_ready, 0);
            checkVal("full_write", rto_core_write, 0);
        end
        applyStimulus(1'b1, 4'hF, 1'b0, 1'b0);
        checkOutput();
        checkVal("full_resume_ready", req_ready, 4'b1000);

        // Flush beats a simultaneous valid, runs 4 cycles, done on the 5th, then requester 0
        applyStimulus(1'b1, 4'b0010, 1'b0, 1'b1);
        checkOutput();
        checkVal("flush_no_write", rto_core_write, 0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0);
            checkOutput();
            checkVal("flush_active", rto_core_flush, 1);
        end
        applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0);
        checkOutput();
        checkVal("flush_done_pulse", flush_done, 1);
        checkVal("flush_done_flush", rto_core_flush, 0);
        applyStimulus(1'b1, 4'hF, 1'b0, 1'b0);
        checkOutput();
        checkVal("post_flush_ready", req_ready, 4'b0001);

        // Reset in the second flush cycle aborts the flush with no done pulse
        applyStimulus(1'b1, 4'b0000, 1'b0, 1'b1);
        checkOutput();
        applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0);
        checkOutput();
        checkVal("abort_flush_pre", rto_core_flush, 1);
        applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0);
        checkOutput();
        checkVal("abort_flush_async", rto_core_flush, 0);
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b1, 4'hF, 1'b0, 1'b0);
            checkOutput();
            checkVal("abort_no_done", flush_done, 0);
            if (k == 0) checkVal("abort_arb_ready", req_ready, 4'b0001);
        end

        // Randomized traffic with occasional full, flush and reset
        for (int k = 0; k < 600; k++) begin
            applyStimulus(($urandom_range(0, 99) != 0), NUM_REQ'($urandom()),
                          ($urandom_range(0, 4) == 0), ($urandom_range(0, 19) == 0));
            checkOutput();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
